// File: rtl/spi_cfg_bank.sv
// Per-channel SPI configuration bank: shadow registers written by the host, committed to active copies only while the engine is idle.
// Reads return shadow/status one cycle after rd_en; a commit request waits in PEND while busy is high.
module spi_cfg_bank #(
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 4,
    localparam int CSW    = $clog2(NUM_CS),
    localparam int ADDR_W = CSW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              busy,
    output logic [CSW-1:0]    cs_sel,
    output logic [DIV_W-1:0]  clk_div,
    output logic [1:0]        mode,
    output logic              lsb_first,
    output logic              irq_en,
    output logic              pending,
    output logic              commit_done,
    output logic              irq
);

    localparam int CH_W = DIV_W + 3;

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    sh_ch_q  [NUM_CS];
    logic [CH_W-1:0]    sh_ch_d  [NUM_CS];
    logic [CH_W-1:0]    act_ch_q [NUM_CS];
    logic [CH_W-1:0]    act_ch_d [NUM_CS];
    logic [CSW-1:0]     sh_cs_q, sh_cs_d, act_cs_q, act_cs_d;
    logic               sh_irq_en_q, sh_irq_en_d, act_irq_en_q, act_irq_en_d;
    logic               irq_flag_q, irq_flag_d;
    logic               commit_done_q, commit_done_d;
    logic [7:0]         dout_q, dout_d;

    logic [CSW-1:0]     idx;
    logic               is_ch;
    logic               ctrl_wr;
    logic [7:0]         rdata;
    logic [CH_W-1:0]    act_entry;
    logic               unused_din;

    assign idx        = addr[CSW-1:0];
    assign is_ch      = addr[ADDR_W-1];
    assign ctrl_wr    = wr_en && !is_ch && (idx == CSW'(0));
    assign unused_din = ^din;

    always_comb begin
        state_d       = state_q;
        sh_ch_d       = sh_ch_q;
        act_ch_d      = act_ch_q;
        sh_cs_d       = sh_cs_q;
        act_cs_d      = act_cs_q;
        sh_irq_en_d   = sh_irq_en_q;
        act_irq_en_d  = act_irq_en_q;
        irq_flag_d    = irq_flag_q;
        commit_done_d = 1'b0;
        dout_d        = dout_q;
        rdata         = '0;

        // Read mux sees pre-write state, so read/write collisions return the old value.
        if (is_ch) begin
            if (int'(idx) < NUM_CS) begin
                rdata[CH_W-1:0] = sh_ch_q[idx];
            end
        end else if (idx == CSW'(0)) begin
            rdata[CSW-1:0] = sh_cs_q;
            rdata[4]       = sh_irq_en_q;
        end else if (idx == CSW'(1)) begin
            rdata[0] = (state_q == PEND);
            rdata[1] = irq_flag_q;
        end
        if (rd_en) begin
            dout_d = rdata;
        end

        if (wr_en) begin
            if (is_ch) begin
                if (int'(idx) < NUM_CS) begin
                    sh_ch_d[idx] = din[CH_W-1:0];
                end
            end else if (idx == CSW'(0)) begin
                sh_cs_d     = din[CSW-1:0];
                sh_irq_en_d = din[4];
            end else if (idx == CSW'(1)) begin
                if (din[1]) begin
                    irq_flag_d = 1'b0;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (ctrl_wr && din[7]) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!busy) begin
                    state_d       = IDLE;
                    act_ch_d      = sh_ch_q;
                    act_cs_d      = sh_cs_q;
                    act_irq_en_d  = sh_irq_en_q;
                    commit_done_d = 1'b1;
                    // Overrides a same-edge STATUS clear.
                    irq_flag_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            for (int i = 0; i < NUM_CS; i++) begin
                sh_ch_q[i]  <= '0;
                act_ch_q[i] <= '0;
            end
            sh_cs_q       <= '0;
            act_cs_q      <= '0;
            sh_irq_en_q   <= 1'b0;
            act_irq_en_q  <= 1'b0;
            irq_flag_q    <= 1'b0;
            commit_done_q <= 1'b0;
            dout_q        <= '0;
        end else begin
            state_q       <= state_d;
            sh_ch_q       <= sh_ch_d;
            act_ch_q      <= act_ch_d;
            sh_cs_q       <= sh_cs_d;
            act_cs_q      <= act_cs_d;
            sh_irq_en_q   <= sh_irq_en_d;
            act_irq_en_q  <= act_irq_en_d;
            irq_flag_q    <= irq_flag_d;
            commit_done_q <= commit_done_d;
            dout_q        <= dout_d;
        end
    end

    always_comb begin
        act_entry = '0;
        if (int'(act_cs_q) < NUM_CS) begin
            act_entry = act_ch_q[act_cs_q];
        end
    end

    assign cs_sel      = act_cs_q;
    assign clk_div     = act_entry[DIV_W-1:0];
    assign mode        = act_entry[DIV_W+1:DIV_W];
    assign lsb_first   = act_entry[DIV_W+2];
    assign irq_en      = act_irq_en_q;
    assign pending     = (state_q == PEND);
    assign commit_done = commit_done_q;
    assign irq         = irq_flag_q & act_irq_en_q;
    assign dout        = dout_q;

endmodule

// File: tb/tb_spi_cfg_bank.sv
// Scoreboard bench for spi_cfg_bank: stimulus queues expected read data and commit snapshots, a negedge monitor checks them.
module tb_spi_cfg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       busy = 1'b0;
    logic [1:0] cs_sel;
    logic [3:0] clk_div;
    logic [1:0] mode;
    logic       lsb_first;
    logic       irq_en;
    logic       pending;
    logic       commit_done;
    logic       irq;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] cs;
        logic [3:0] div;
        logic [1:0] mode;
        logic       lsb;
        logic       ien;
        logic       irq;
    } exp_t;

    exp_t       cq [$];
    logic [7:0] rq [$];
    logic       rd_d1 = 1'b0;

    spi_cfg_bank #(.NUM_CS(4), .DIV_W(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .din(din),
        .dout(dout), .busy(busy), .cs_sel(cs_sel), .clk_div(clk_div), .mode(mode),
        .lsb_first(lsb_first), .irq_en(irq_en), .pending(pending),
        .commit_done(commit_done), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) rd_d1 <= 1'b0;
        else      rd_d1 <= rd_en;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or a commit pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (rd_d1) begin
                if (rq.size() == 0) chk("read_unexpected", 8'h01, 8'h00);
                else chk("read_data", dout, rq.pop_front());
            end
            if (commit_done) begin
                exp_t e, a;
                a = '{cs: cs_sel, div: clk_div, mode: mode, lsb: lsb_first, ien: irq_en, irq: irq};
                if (cq.size() == 0) begin
                    chk("commit_unexpected", 8'h01, 8'h00);
                end else begin
                    e = cq.pop_front();
                    total++;
                    if (a !== e) begin
                        bad++;
                        $display("FAIL commit_outputs: got %b expected %b (cs,div,mode,lsb,ien,irq)", a, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; din = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp);
        addr = a; rd_en = 1'b1;
        rq.push_back(exp);
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then reset again while a commit is pending
        repeat (2) step();
        chk("rst_pending", {7'd0, pending}, 8'h00);
        chk("rst_dout", dout, 8'h00);
        rst = 1'b1;
        step();
        busy = 1'b1;
        wr(3'd0, 8'h80);
        step();
        chk("pend_before_rst", {7'd0, pending}, 8'h01);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_pend_pending", {7'd0, pending}, 8'h00);
        chk("rst_mid_pend_outs", {cs_sel, clk_div, mode}, 8'h00);
        chk("rst_mid_pend_flags", {4'd0, lsb_first, irq_en, irq, commit_done}, 8'h00);
        step();
        rst = 1'b1;
        busy = 1'b0;
        repeat (2) step();
        chk("post_rst_pending", {7'd0, pending}, 8'h00);
        rd(3'd4, 8'h00);

        // 2: shadow write does not touch active outputs
        wr(3'd5, 8'h6B);
        rd(3'd5, 8'h6B);
        step();
        chk("shadow_only_div", {4'd0, clk_div}, 8'h00);

        // 3: commit with busy low
        cq.push_back('{cs: 2'd1, div: 4'hB, mode: 2'd2, lsb: 1'b1, ien: 1'b1, irq: 1'b1});
        wr(3'd0, 8'h91);
        chk("commit_pending", {7'd0, pending}, 8'h01);
        chk("commit_not_yet", {7'd0, commit_done}, 8'h00);
        step();
        chk("commit_pend_clear", {7'd0, pending}, 8'h00);
        step();
        chk("commit_done_1cyc", {7'd0, commit_done}, 8'h00);

        // 4: commit held off by busy, shadow write while pending
        busy = 1'b1;
        wr(3'd0, 8'h91);
        wr(3'd5, 8'h03);
        repeat (3) step();
        chk("busy_pending", {7'd0, pending}, 8'h01);
        chk("busy_hold_outs", {clk_div, mode, 1'b0, lsb_first}, {4'hB, 2'd2, 1'b0, 1'b1});
        cq.push_back('{cs: 2'd1, div: 4'h3, mode: 2'd0, lsb: 1'b0, ien: 1'b1, irq: 1'b1});
        busy = 1'b0;
        step();
        step();

        // 5: status clear collides with commit; set wins
        busy = 1'b1;
        wr(3'd0, 8'h91);
        busy = 1'b0;
        cq.push_back('{cs: 2'd1, div: 4'h3, mode: 2'd0, lsb: 1'b0, ien: 1'b1, irq: 1'b1});
        wr(3'd1, 8'h02);
        chk("set_wins_irq", {7'd0, irq}, 8'h01);
        rd(3'd1, 8'h02);
        wr(3'd1, 8'h02);
        chk("irq_cleared", {7'd0, irq}, 8'h00);
        rd(3'd1, 8'h00);

        // 6: unmapped globals, unused channel bits, CTRL readback, read/write collision
        rd(3'd2, 8'h00);
        rd(3'd3, 8'h00);
        wr(3'd6, 8'hFF);
        rd(3'd6, 8'h7F);
        rd(3'd0, 8'h11);
        addr = 3'd6; din = 8'h05; wr_en = 1'b1; rd_en = 1'b1;
        rq.push_back(8'h7F);
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        rd(3'd6, 8'h05);
        step();
        chk("dout_hold", dout, 8'h05);

        repeat (3) step();
        chk("read_queue_empty", 8'(rq.size()), 8'h00);
        chk("commit_queue_empty", 8'(cq.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
